seq_detector: RTL and testbench
===============================

Name: seq_detector

Overview:
- Serial sequence detector. Consumes a qualified serial bit stream and flags each occurrence of a fixed PAT_W-bit pattern.
- Sits directly upstream of the D-flip-flop state/output registers in the sseq datapath. Its registered match pulse drives the D input of the downstream flag flip-flop.
- Also maintains a saturating match counter and exposes the current FSM state for debug.

Parameters:
- PAT_W, 4, pattern length in bits (2..8).
- PATTERN, 4'b1011, target sequence. MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = state restarts at 0 after a match.
- CNT_W, 8, width of the match counter.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is consumed on this edge only when 1.
- clr_cnt  input  1  synchronous clear of match_cnt.
- match  output  1  one-cycle registered pulse per detected pattern.
- match_cnt  output  CNT_W  number of matches, saturating.
- state  output  $clog2(PAT_W+1)  number of pattern bits currently matched (0..PAT_W-1).

Behaviour:
- Reset: synchronous, active-high, on clock CLK. Reset=1 at a rising edge sets state=0, match=0, match_cnt=0. Reset overrides every other input in that cycle, including an in-progress partial match.
- state meaning: length of the longest pattern prefix equal to a suffix of the consumed stream, restricted to values < PAT_W.
- din_valid=0: state, match_cnt hold; match=0 next cycle.
- din_valid=1, din == PATTERN[PAT_W-1-state]:
  - If state+1 < PAT_W: state <= state+1.
  - Else it is a full match: match <= 1, match_cnt increments, and state <= B if OVERLAP=1 or 0 if OVERLAP=0. B = longest proper border of PATTERN (1 for 1011).
- din_valid=1, mismatch: state <= KMP fallback, i.e. the longest prefix of PATTERN that is a suffix of (consumed prefix & din); may be 0. Example for 1011: state 3 + din 0 -> 2; state 1 + din 1 -> 1; state 2 + din 0 -> 0.
- Latency: match rises exactly one CLK after the edge that consumed the final pattern bit. It stays high one cycle unless the next consumed bit completes another match; back-to-back is only possible when B=PAT_W-1.
- Next-state table: computed at elaboration from PATTERN. No runtime pattern loading.
- match_cnt:
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 sets it to 0. If clr_cnt and a match occur in the same cycle, the result is 0; clear wins.
  - match still pulses while the counter is saturated.
- X on din while din_valid=0 must not affect state.

Decomposition:
- Package seq_pkg holds:
  - state width function (clog2 of PAT_W+1);
  - function computing the border/fallback table from PATTERN and PAT_W;
  - default PATTERN constant.
- Sub-module seq_next_state: purely combinational (state, din, din_valid) -> (next_state, hit), parameterised by PAT_W/PATTERN/OVERLAP.
- The top holds the state register, match register and counter.

Test Plan:
- Reset mid-stream: feed 101, assert Reset one cycle, then 1011 -> state 0 after Reset; single match pulse 1 cycle after the 4th post-reset bit; match_cnt=1.
- OVERLAP=1, stream 1011011 all valid -> match pulses after bit 4 and bit 7; match_cnt=2.
- OVERLAP=0, stream 1011011 -> exactly one pulse, after bit 4; match_cnt=1.
- KMP fallback, stream 10101011 -> state sequence 1,2,3,2,3,2,3,match; single pulse after bit 8.
- din_valid gaps: 1,0,1,1 with din_valid low for 3 cycles between each bit and din toggling randomly while invalid -> one match; state holds during gaps.
- Counter: CNT_W=2, five matches -> match_cnt sticks at 3, match still pulses. Then clr_cnt asserted in the same cycle as a match -> match_cnt=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants and elaboration-time helpers for the serial sequence detector.
// The fallback function builds the KMP transition table from the pattern.
package seq_pkg;

    localparam int unsigned DEFAULT_PAT_W = 4;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    function automatic int unsigned state_width(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Longest pattern prefix shorter than pat_w that is a suffix of
    // (first s pattern bits, then b). Covers both advance and fallback.
    function automatic int unsigned kmp_next(input int unsigned pattern,
                                             input int unsigned pat_w,
                                             input int unsigned s,
                                             input int unsigned b);
        int unsigned seq;
        int unsigned kmax;
        int unsigned best;
        seq  = ((pattern >> (pat_w - s)) << 1) | (b & 32'd1);
        kmax = (s + 1 < pat_w) ? s + 1 : pat_w - 1;
        best = 0;
        for (int unsigned k = 1; k <= kmax; k++) begin
            if ((seq & ((32'd1 << k) - 32'd1)) == (pattern >> (pat_w - k))) begin
                best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_next_state.sv
// Combinational next-state logic for the sequence detector.
// Transition table is fixed at elaboration from PATTERN.
module seq_next_state
    import seq_pkg::*;
#(
    parameter int unsigned      PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter bit               OVERLAP = 1'b1,
    localparam int unsigned     SW      = state_width(PAT_W)
) (
    input  logic [SW-1:0] state,
    input  logic          din,
    input  logic          din_valid,
    output logic [SW-1:0] next_state,
    output logic          hit
);

    localparam int unsigned NUM_S = 2 ** SW;
    localparam logic [SW-1:0] LAST = SW'(PAT_W - 1);

    logic [SW-1:0] tbl0    [NUM_S];
    logic [SW-1:0] tbl1    [NUM_S];
    logic          exp_bit [NUM_S];

    // Unreachable encodings fall back to 0 so a corrupted state self-recovers.
    for (genvar s = 0; s < NUM_S; s++) begin : g_tbl
        if (s < PAT_W) begin : g_live
            assign tbl0[s]    = SW'(kmp_next(32'(PATTERN), PAT_W, s, 0));
            assign tbl1[s]    = SW'(kmp_next(32'(PATTERN), PAT_W, s, 1));
            assign exp_bit[s] = PATTERN[PAT_W-1-s];
        end else begin : g_pad
            assign tbl0[s]    = '0;
            assign tbl1[s]    = '0;
            assign exp_bit[s] = 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        hit        = 1'b0;
        if (din_valid) begin
            next_state = din ? tbl1[state] : tbl0[state];
            if (din == exp_bit[state] && state == LAST) begin
                hit = 1'b1;
                if (!OVERLAP) begin
                    next_state = '0;
                end
            end
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Serial sequence detector: flags each occurrence of PATTERN with a registered
// one-cycle pulse and keeps a saturating match count.
module seq_detector
    import seq_pkg::*;
#(
    parameter int unsigned      PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8,
    localparam int unsigned     SW      = state_width(PAT_W)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SW-1:0]    state
);

    logic [SW-1:0]    state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    seq_next_state #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .OVERLAP (OVERLAP)
    ) u_next_state (
        .state      (state_q),
        .din        (din),
        .din_valid  (din_valid),
        .next_state (state_d),
        .hit        (hit)
    );

    // Clear beats a simultaneous match; the pulse itself is never suppressed.
    always_comb begin
        match_d = hit;
        cnt_d   = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (hit && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state     = state_q;
    assign match     = match_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: three configurations share one stimulus stream and are
// checked every cycle against a history-based model, plus literal expectations.
module tb_seq_detector;

    logic       CLK = 1'b0;
    logic       Reset, din, din_valid, clr_cnt;
    logic       a_match, b_match, c_match;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] c_cnt;
    logic [2:0] a_state, b_state, c_state;

    always #5 CLK = ~CLK;

    seq_detector u_dut_a (
        .CLK(CLK), .Reset(Reset), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .match(a_match), .match_cnt(a_cnt), .state(a_state)
    );

    seq_detector #(.OVERLAP(1'b0)) u_dut_b (
        .CLK(CLK), .Reset(Reset), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .match(b_match), .match_cnt(b_cnt), .state(b_state)
    );

    seq_detector #(.CNT_W(2)) u_dut_c (
        .CLK(CLK), .Reset(Reset), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .match(c_match), .match_cnt(c_cnt), .state(c_state)
    );

    localparam int PAT = 'b1011;
    localparam int PW  = 4;

    int ovl  [3] = '{1, 0, 1};
    int cmax [3] = '{255, 255, 3};
    int hist [3];
    int hlen [3];
    int e_match [3];
    int e_cnt   [3];
    int e_state [3];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: keep the consumed bits, match when the newest PW bits equal the pattern,
    // state is the longest pattern prefix seen at the end of the history.
    task automatic model_step(input bit rst, input bit d, input bit v, input bit clr);
        for (int m = 0; m < 3; m++) begin
            if (rst) begin
                hist[m] = 0; hlen[m] = 0; e_match[m] = 0; e_cnt[m] = 0;
            end else begin
                e_match[m] = 0;
                if (v) begin
                    hist[m] = ((hist[m] << 1) | int'(d)) & 'hff;
                    if (hlen[m] < 8) hlen[m]++;
                    if (hlen[m] >= PW && (hist[m] & 'hf) == PAT) begin
                        e_match[m] = 1;
                        if (ovl[m] == 0) begin
                            hist[m] = 0; hlen[m] = 0;
                        end
                    end
                end
                if (clr) e_cnt[m] = 0;
                else if (e_match[m] == 1 && e_cnt[m] < cmax[m]) e_cnt[m]++;
            end
            e_state[m] = 0;
            for (int k = 1; k < PW; k++) begin
                if (k <= hlen[m] && (hist[m] & ((1 << k) - 1)) == (PAT >> (PW - k)))
                    e_state[m] = k;
            end
        end
    endtask

    task automatic check_all();
        chk("a.match", int'(a_match), e_match[0]);
        chk("a.cnt",   int'(a_cnt),   e_cnt[0]);
        chk("a.state", int'(a_state), e_state[0]);
        chk("b.match", int'(b_match), e_match[1]);
        chk("b.cnt",   int'(b_cnt),   e_cnt[1]);
        chk("b.state", int'(b_state), e_state[1]);
        chk("c.match", int'(c_match), e_match[2]);
        chk("c.cnt",   int'(c_cnt),   e_cnt[2]);
        chk("c.state", int'(c_state), e_state[2]);
    endtask

    // Inputs change at the falling edge; outputs are checked at the next falling edge.
    task automatic step(input bit rst, input logic d, input bit v, input bit clr);
        Reset = rst; din = d; din_valid = v; clr_cnt = clr;
        @(posedge CLK);
        #1;
        model_step(rst, d, v, clr);
        @(negedge CLK);
        check_all();
    endtask

    task automatic feed(input int bits, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'((bits >> (n - 1 - i)) & 1), 1'b1, 1'b0);
    endtask

    int   lit_a [8];
    int   lit_b [8];
    bit   r, v, c;
    logic d;

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst.state", int'(a_state), 0);
        chk("rst.match", int'(a_match), 0);
        chk("rst.cnt", int'(a_cnt), 0);

        // Reset in the middle of a partial match
        step(1'b0, 1'b0, 1'b0, 1'b0);
        feed('b101, 3);
        chk("mid.partial", int'(a_state), 3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mid.state", int'(a_state), 0);
        feed('b101, 3);
        chk("mid.nomatch", int'(a_match), 0);
        feed('b1, 1);
        chk("mid.match", int'(a_match), 1);
        chk("mid.cnt", int'(a_cnt), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid.pulse_end", int'(a_match), 0);

        // Overlapping vs non-overlapping on 1011011
        step(1'b1, 1'b0, 1'b0, 1'b0);
        lit_a = '{0, 0, 0, 1, 0, 0, 1, 0};
        lit_b = '{0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'(('b1011011 >> (6 - i)) & 1), 1'b1, 1'b0);
            chk($sformatf("ovl.a_match[%0d]", i), int'(a_match), lit_a[i]);
            chk($sformatf("ovl.b_match[%0d]", i), int'(b_match), lit_b[i]);
        end
        chk("ovl.a_cnt", int'(a_cnt), 2);
        chk("ovl.b_cnt", int'(b_cnt), 1);
        chk("ovl.b_state", int'(b_state), 1);

        // KMP fallback on 10101011
        step(1'b1, 1'b0, 1'b0, 1'b0);
        lit_a = '{1, 2, 3, 2, 3, 2, 3, 1};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'(('b10101011 >> (7 - i)) & 1), 1'b1, 1'b0);
            chk($sformatf("kmp.state[%0d]", i), int'(a_state), lit_a[i]);
            chk($sformatf("kmp.match[%0d]", i), int'(a_match), (i == 7) ? 1 : 0);
        end

        // Valid gaps with junk on din while invalid
        step(1'b1, 1'b0, 1'b0, 1'b0);
        lit_a = '{1, 2, 3, 1, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'(('b1011 >> (3 - i)) & 1), 1'b1, 1'b0);
            chk($sformatf("gap.match[%0d]", i), int'(a_match), (i == 3) ? 1 : 0);
            for (int g = 0; g < 3; g++) begin
                d = ($urandom_range(0, 2) == 0) ? 1'bx : 1'($urandom_range(0, 1));
                step(1'b0, d, 1'b0, 1'b0);
                chk($sformatf("gap.hold[%0d]", i), int'(a_state), lit_a[i]);
            end
        end
        chk("gap.cnt", int'(a_cnt), 1);

        // Counter saturation, then clear coinciding with a match
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) feed('b1011, 4);
        chk("sat.c_cnt", int'(c_cnt), 3);
        chk("sat.c_match", int'(c_match), 1);
        chk("sat.a_cnt", int'(a_cnt), 5);
        feed('b101, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr.c_cnt", int'(c_cnt), 0);
        chk("clr.a_cnt", int'(a_cnt), 0);
        chk("clr.match", int'(c_match), 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 99) < 70);
            c = ($urandom_range(0, 99) < 3);
            d = 1'($urandom_range(0, 1));
            if (!v && $urandom_range(0, 3) == 0) d = 1'bx;
            step(r, d, v, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
